// File: rtl/npg_pkg.sv
// Shared widths, defaults and FSM encoding for the neural pulse generator scheduler.
package npg_pkg;

    localparam int NCH_DEF = 4;
    localparam int PER_W   = 12;
    localparam int AMP_W   = 6;
    localparam int ELE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } npg_state_e;

    typedef struct packed {
        logic [PER_W-1:0] period;
        logic [AMP_W-1:0] amplitude;
        logic [ELE_W-1:0] electrode1;
        logic [ELE_W-1:0] electrode2;
    } npg_cfg_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/npg_rr_arbiter.sv
// Round-robin pick among pending channels, starting the search just after last_grant.
module npg_rr_arbiter
    import npg_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int IW  = cnt_width(NCH)
) (
    input  logic [NCH-1:0] pending,
    input  logic [IW-1:0]  last_grant,
    input  logic           request_en,
    output logic           grant_valid,
    output logic [IW-1:0]  grant_idx
);

    always_comb begin
        logic [IW-1:0] idx;
        idx         = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Farthest candidate first, so the nearest pending channel overwrites it.
        for (int k = NCH; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NCH);
            if (request_en && pending[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/npg_pulse_scheduler.sv
// Per-channel period timers feeding one shared pulse engine through a round-robin
// arbiter; IDLE/WAIT/GAP sequencing with timeout fault and per-channel overrun flags.
module npg_pulse_scheduler
    import npg_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [NCH-1:0]   chan_enable,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [PER_W-1:0] cfg_period,
    input  logic [AMP_W-1:0] cfg_amplitude,
    input  logic [ELE_W-1:0] cfg_electrode1,
    input  logic [ELE_W-1:0] cfg_electrode2,
    input  logic             pulse_done,
    input  logic             fault_clr,
    output logic             pulse_start,
    output logic [1:0]       active_ch,
    output logic [AMP_W-1:0] amplitude_out,
    output logic [ELE_W-1:0] electrode1_out,
    output logic [ELE_W-1:0] electrode2_out,
    output logic             busy,
    output logic [NCH-1:0]   overrun,
    output logic             fault
);

    localparam int IW = cnt_width(NCH);
    localparam int TW = cnt_width(TIMEOUT);
    localparam int GW = cnt_width(GAP);

    npg_cfg_t [NCH-1:0]              cfg_q, cfg_d;
    logic     [NCH-1:0][PER_W-1:0]   cnt_q, cnt_d;
    logic     [NCH-1:0]              pend_q, pend_d, ovr_q, ovr_d;
    logic     [NCH-1:0]              run, tick, wr_hit, gnt_vec;
    npg_cfg_t                        cfg_in, gcfg;

    npg_state_e     state_q, state_d;
    logic [TW-1:0]  wcnt_q, wcnt_d;
    logic [GW-1:0]  gcnt_q, gcnt_d;
    logic [IW-1:0]  last_q, last_d;
    logic           fault_q, fault_d, timeout;
    logic           start_q;
    logic [1:0]     ach_q;
    logic [AMP_W-1:0] amp_q;
    logic [ELE_W-1:0] e1_q, e2_q;

    logic           request_en, grant_valid;
    logic [IW-1:0]  grant_idx;

    assign cfg_in     = '{period: cfg_period, amplitude: cfg_amplitude,
                          electrode1: cfg_electrode1, electrode2: cfg_electrode2};
    assign request_en = (state_q == ST_IDLE) && enable && !fault_q;
    assign gcfg       = cfg_q[grant_idx];

    npg_rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .pending     (pend_q),
        .last_grant  (last_q),
        .request_en  (request_en),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Channel timers: a tick in a grant cycle re-arms pending; a cfg write beats overrun.
    always_comb begin
        run = '0; tick = '0; wr_hit = '0; gnt_vec = '0;
        cnt_d = cnt_q; pend_d = pend_q; ovr_d = ovr_q; cfg_d = cfg_q;
        for (int i = 0; i < NCH; i++) begin
            run[i]     = enable && chan_enable[i];
            wr_hit[i]  = cfg_we && (cfg_addr == 2'(i));
            gnt_vec[i] = grant_valid && (grant_idx == IW'(i));
            tick[i]    = run[i] && (cfg_q[i].period != '0) &&
                         (cnt_q[i] == cfg_q[i].period - PER_W'(1));
            if (!run[i] || wr_hit[i] || tick[i] || cfg_q[i].period == '0)
                cnt_d[i] = '0;
            else
                cnt_d[i] = cnt_q[i] + PER_W'(1);
            if (!run[i])         pend_d[i] = 1'b0;
            else if (tick[i])    pend_d[i] = 1'b1;
            else if (gnt_vec[i]) pend_d[i] = 1'b0;
            if (wr_hit[i])                                  ovr_d[i] = 1'b0;
            else if (tick[i] && pend_q[i] && !gnt_vec[i])   ovr_d[i] = 1'b1;
            if (wr_hit[i]) cfg_d[i] = cfg_in;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        last_d  = last_q;
        timeout = 1'b0;
        unique case (state_q)
            ST_IDLE: if (grant_valid) begin
                state_d = ST_WAIT;
                wcnt_d  = '0;
                last_d  = grant_idx;
            end
            ST_WAIT: begin
                // Enable is deliberately ignored here so a started pulse always completes.
                if (pulse_done || wcnt_q == TW'(TIMEOUT - 1)) begin
                    timeout = !pulse_done;
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                    gcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (gcnt_q == GW'(GAP - 1)) state_d = ST_IDLE;
                else                        gcnt_d  = gcnt_q + GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        fault_d = timeout ? 1'b1 : (fault_clr ? 1'b0 : fault_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q  <= '0;
            cnt_q  <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            cfg_q  <= cfg_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
            last_q  <= IW'(NCH - 1);
            fault_q <= 1'b0;
            start_q <= 1'b0;
            ach_q   <= '0;
            amp_q   <= '0;
            e1_q    <= '0;
            e2_q    <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            last_q  <= last_d;
            fault_q <= fault_d;
            start_q <= grant_valid;
            // Pulse parameters are snapshotted so later cfg writes leave this pulse alone.
            if (grant_valid) begin
                ach_q <= 2'(grant_idx);
                amp_q <= gcfg.amplitude;
                e1_q  <= gcfg.electrode1;
                e2_q  <= gcfg.electrode2;
            end
        end
    end

    assign pulse_start    = start_q;
    assign active_ch      = ach_q;
    assign amplitude_out  = (state_q == ST_WAIT) ? amp_q : '0;
    assign electrode1_out = e1_q;
    assign electrode2_out = e2_q;
    assign busy           = (state_q != ST_IDLE);
    assign overrun        = ovr_q;
    assign fault          = fault_q;

endmodule

// File: tb/tb_npg_pulse_scheduler.sv
// Self-checking bench: vector table, directed multi-cycle scenarios, random vs. reference model.
module tb_npg_pulse_scheduler;

    localparam int NCH = 4, GAP = 2, TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset, enable, cfg_we, fault_clr, pulse_done, auto_mode, auto_done, man_done;
    logic [3:0]  chan_enable;
    logic [1:0]  cfg_addr, active_ch;
    logic [11:0] cfg_period;
    logic [5:0]  cfg_amplitude, amplitude_out;
    logic [3:0]  cfg_electrode1, cfg_electrode2, electrode1_out, electrode2_out, overrun;
    logic        pulse_start, busy, fault;

    int passed = 0, total = 0, cyc = 0, done_dly = 4, dcnt = 0;

    assign pulse_done = auto_mode ? auto_done : man_done;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    npg_pulse_scheduler #(.NCH(NCH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .chan_enable(chan_enable),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_period(cfg_period),
        .cfg_amplitude(cfg_amplitude), .cfg_electrode1(cfg_electrode1),
        .cfg_electrode2(cfg_electrode2), .pulse_done(pulse_done), .fault_clr(fault_clr),
        .pulse_start(pulse_start), .active_ch(active_ch), .amplitude_out(amplitude_out),
        .electrode1_out(electrode1_out), .electrode2_out(electrode2_out),
        .busy(busy), .overrun(overrun), .fault(fault)
    );

    // Engine stand-in: answers pulse_done done_dly cycles after each start (0 = never).
    initial begin
        auto_done = 1'b0;
        forever begin
            @(negedge clk);
            auto_done = 1'b0;
            if (reset) dcnt = 0;
            else begin
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) auto_done = 1'b1;
                end
                if (pulse_start && done_dly > 0) dcnt = done_dly;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        enable = 0; chan_enable = '0; cfg_we = 0; cfg_addr = '0; cfg_period = '0;
        cfg_amplitude = '0; cfg_electrode1 = '0; cfg_electrode2 = '0;
        fault_clr = 0; man_done = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cfg(input int ch, input int per, input int amp, input int e1, input int e2);
        @(negedge clk);
        cfg_we = 1; cfg_addr = 2'(ch); cfg_period = 12'(per);
        cfg_amplitude = 6'(amp); cfg_electrode1 = 4'(e1); cfg_electrode2 = 4'(e2);
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic wait_start(input int bound, output bit ok);
        ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (pulse_start) begin ok = 1; break; end
        end
    endtask

    function automatic logic [22:0] dut_outs();
        return {pulse_start, active_ch, amplitude_out, electrode1_out, electrode2_out,
                busy, overrun, fault};
    endfunction

    // ---------------- reference model ----------------
    int m_per[NCH], m_amp[NCH], m_e1[NCH], m_e2[NCH], m_cnt[NCH];
    bit m_pend[NCH], m_ovr[NCH];
    int m_last, m_phase, m_waited, m_gapleft, m_ach, m_lamp, m_le1, m_le2;
    bit m_fault, m_start;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_per[i] = 0; m_amp[i] = 0; m_e1[i] = 0; m_e2[i] = 0; m_cnt[i] = 0;
            m_pend[i] = 0; m_ovr[i] = 0;
        end
        m_last = NCH - 1; m_phase = 0; m_waited = 0; m_gapleft = 0;
        m_ach = 0; m_lamp = 0; m_le1 = 0; m_le2 = 0; m_fault = 0; m_start = 0;
    endtask

    // phase: 0 idle, 1 pulse in flight, 2 guard interval
    task automatic model_step();
        bit run[NCH], tick[NCH], wr;
        int g;
        bit tmo;
        g = -1; tmo = 0;
        for (int i = 0; i < NCH; i++) begin
            run[i]  = enable && chan_enable[i];
            tick[i] = run[i] && m_per[i] > 0 && m_cnt[i] == m_per[i] - 1;
        end
        if (m_phase == 0 && enable && !m_fault)
            for (int k = 1; k <= NCH; k++)
                if (g < 0 && m_pend[(m_last + k) % NCH]) g = (m_last + k) % NCH;
        m_start = (g >= 0);
        if (m_phase == 1) begin
            m_waited++;
            if (man_done || m_waited == TIMEOUT) begin
                tmo = !man_done;
                m_phase = (GAP > 0) ? 2 : 0;
                m_gapleft = GAP;
            end
        end else if (m_phase == 2) begin
            m_gapleft--;
            if (m_gapleft == 0) m_phase = 0;
        end
        if (g >= 0) begin
            m_phase = 1; m_waited = 0; m_last = g; m_ach = g;
            m_lamp = m_amp[g]; m_le1 = m_e1[g]; m_le2 = m_e2[g];
        end
        if (tmo) m_fault = 1;
        else if (fault_clr) m_fault = 0;
        for (int i = 0; i < NCH; i++) begin
            wr = cfg_we && (int'(cfg_addr) == i);
            m_ovr[i]  = wr ? 1'b0 : (m_ovr[i] || (tick[i] && m_pend[i] && g != i));
            m_pend[i] = !run[i] ? 1'b0 : tick[i] ? 1'b1 : (g == i) ? 1'b0 : m_pend[i];
            m_cnt[i]  = (!run[i] || wr || m_per[i] == 0 || tick[i]) ? 0 : m_cnt[i] + 1;
            if (wr) begin
                m_per[i] = int'(cfg_period); m_amp[i] = int'(cfg_amplitude);
                m_e1[i] = int'(cfg_electrode1); m_e2[i] = int'(cfg_electrode2);
            end
        end
    endtask

    function automatic logic [22:0] model_outs();
        logic [3:0] ov;
        for (int i = 0; i < NCH; i++) ov[i] = m_ovr[i];
        return {m_start, 2'(m_ach), (m_phase == 1) ? 6'(m_lamp) : 6'd0, 4'(m_le1), 4'(m_le2),
                m_phase != 0, ov, m_fault};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        int period; int amp; int dly; int exp_gap; bit exp_ovr;
    } vec_t;
    vec_t vecs[5];

    initial begin
        bit ok;
        int t1, t2, nb, ns;
        int ts[4];

        vecs[0] = '{10, 21, 4, 10, 1'b0};
        vecs[1] = '{20, 63, 4, 20, 1'b0};
        vecs[2] = '{ 8,  5, 4,  8, 1'b0};
        vecs[3] = '{ 5, 33, 4,  8, 1'b1};
        vecs[4] = '{10,  7, 1, 10, 1'b0};

        reset = 1'b1; auto_mode = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset outputs", 64'(dut_outs()), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset idle", 64'(dut_outs()), 64'd0);

        for (int r = 0; r < 5; r++) begin
            do_reset();
            done_dly = vecs[r].dly;
            cfg(0, vecs[r].period, vecs[r].amp, 1, 2);
            enable = 1; chan_enable = 4'b0001;
            wait_start(60, ok);
            check($sformatf("vec%0d first start", r), 64'(ok), 64'd1);
            check($sformatf("vec%0d amp in wait", r), 64'(amplitude_out), 64'(vecs[r].amp));
            check($sformatf("vec%0d electrodes", r), 64'({electrode1_out, electrode2_out}), 64'h12);
            wait_start(60, ok); t1 = cyc;
            wait_start(60, ok); t2 = cyc;
            check($sformatf("vec%0d start interval", r), 64'(t2 - t1), 64'(vecs[r].exp_gap));
            check($sformatf("vec%0d overrun", r), 64'(overrun), 64'(vecs[r].exp_ovr));
            ok = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (!busy) begin ok = 1; break; end
            end
            check($sformatf("vec%0d idle reached", r), 64'(ok), 64'd1);
            check($sformatf("vec%0d amp zero idle", r), 64'(amplitude_out), 64'd0);
        end

        // All four channels tick together: strict 0,1,2,3 order, 5-cycle spacing
        // (2 WAIT + 2 GAP + 1 IDLE grant cycle with a 1-cycle engine).
        do_reset();
        done_dly = 1;
        for (int c = 0; c < 4; c++) cfg(c, 20, 10 + c, c, 15 - c);
        enable = 1; chan_enable = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_start(40, ok);
            ts[k] = cyc;
            check($sformatf("rr start %0d seen", k), 64'(ok), 64'd1);
            check($sformatf("rr order %0d", k), 64'(active_ch), 64'(k));
            if (k > 0) check($sformatf("rr spacing %0d", k), 64'(ts[k] - ts[k-1]), 64'd5);
        end
        repeat (40) @(negedge clk);
        check("rr no overrun", 64'(overrun), 64'd0);

        // Slow engine on a fast channel: overrun, then a cfg write clears it.
        do_reset();
        done_dly = 8;
        cfg(1, 3, 9, 4, 5);
        enable = 1; chan_enable = 4'b0010;
        repeat (40) @(negedge clk);
        check("ovr set", 64'(overrun), 64'b0010);
        cfg(1, 0, 9, 4, 5);
        check("ovr cleared by cfg", 64'(overrun), 64'd0);
        repeat (20) @(negedge clk);
        check("ovr stays clear", 64'(overrun), 64'd0);

        // Engine never answers: fault exactly TIMEOUT cycles after start, scheduling frozen.
        do_reset();
        done_dly = 0;
        cfg(0, 10, 20, 1, 1);
        enable = 1; chan_enable = 4'b0001;
        wait_start(40, ok);
        t1 = cyc;
        check("timeout start seen", 64'(ok), 64'd1);
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (fault) begin ok = 1; break; end
        end
        check("fault raised", 64'(ok), 64'd1);
        check("fault latency", 64'(cyc - t1), 64'(TIMEOUT));
        ns = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (pulse_start) ns++;
        end
        check("no start under fault", 64'(ns), 64'd0);
        check("fault sticky", 64'(fault), 64'd1);
        fault_clr = 1;
        @(negedge clk);
        fault_clr = 0;
        check("fault cleared", 64'(fault), 64'd0);
        done_dly = 4;
        wait_start(30, ok);
        check("resume after clr", 64'(ok), 64'd1);

        // Enable dropped one cycle into the pulse: pulse and guard still complete.
        do_reset();
        done_dly = 4;
        cfg(0, 10, 30, 2, 3);
        enable = 1; chan_enable = 4'b0001;
        wait_start(40, ok);
        nb = busy ? 1 : 0;
        @(negedge clk);
        if (busy) nb++;
        enable = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
        end
        check("busy span after enable drop", 64'(nb), 64'd7);
        ns = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (pulse_start) ns++;
        end
        check("no start after enable drop", 64'(ns), 64'd0);

        // Asynchronous reset mid-pulse, then first grant goes to ch0.
        do_reset();
        done_dly = 8;
        cfg(0, 10, 45, 3, 9);
        enable = 1; chan_enable = 4'b0001;
        wait_start(40, ok);
        repeat (2) @(negedge clk);
        check("amp before async reset", 64'(amplitude_out), 64'd45);
        #2 reset = 1'b1;
        #1 check("async reset outputs", 64'(dut_outs()), 64'd0);
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cfg(0, 6, 1, 1, 1);
        cfg(1, 6, 2, 2, 2);
        enable = 1; chan_enable = 4'b0011;
        wait_start(40, ok);
        check("first grant after reset", 64'({ok, active_ch}), 64'({1'b1, 2'd0}));

        // Randomized run against the reference model.
        do_reset();
        auto_mode = 0;
        model_reset();
        model_step();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            total++;
            if (dut_outs() === model_outs()) passed++;
            else begin
                $display("FAIL random cycle %0d: got 0x%0h, want 0x%0h", c, dut_outs(), model_outs());
                break;
            end
            enable = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 19) == 0) chan_enable = 4'($urandom);
            cfg_we = ($urandom_range(0, 11) == 0);
            cfg_addr = 2'($urandom);
            cfg_period = 12'($urandom_range(0, 14));
            cfg_amplitude = 6'($urandom);
            cfg_electrode1 = 4'($urandom);
            cfg_electrode2 = 4'($urandom);
            man_done = ((c % 1000) < 600) && ($urandom_range(0, 3) == 0);
            fault_clr = ($urandom_range(0, 39) == 0);
            model_step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/npg_pulse_scheduler.md
NPG_PULSE_SCHEDULER -- requirements
Module: npg_pulse_scheduler

Interface
REQ-001 SHALL have parameter NCH, 4: number of stimulation channels sharing one pulse engine.
REQ-002 SHALL have parameter GAP, 2: inter-pulse guard interval, in clk cycles.
REQ-003 SHALL have parameter TIMEOUT, 255: maximum number of WAIT cycles before a pulse is aborted.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  global scheduling enable.
REQ-007 SHALL have port chan_enable  in  NCH  per-channel enable.
REQ-008 SHALL have config-write ports: cfg_we in 1; cfg_addr in 2; cfg_period in 12 (clk cycles); cfg_amplitude in 6; cfg_electrode1 in 4; cfg_electrode2 in 4.
REQ-009 SHALL have port pulse_done  in  1  one-cycle completion strobe from the pulse engine.
REQ-010 SHALL have port fault_clr  in  1  clears fault.
REQ-011 SHALL have port pulse_start  out  1  one-cycle engine start strobe.
REQ-012 SHALL have these pulse-selection outputs: active_ch out 2; amplitude_out out 6; electrode1_out out 4; electrode2_out out 4.
REQ-013 SHALL have these status outputs: busy out 1; overrun out NCH (sticky); fault out 1 (sticky).

Function
REQ-014 SHALL store period, amplitude and electrodes for channel cfg_addr on each clk edge with cfg_we=1; the same write SHALL zero that channel's counter and clear its overrun bit.
REQ-015 SHALL run one 12-bit up-counter per channel while enable and chan_enable[i] are both 1; at cnt==period-1 the counter SHALL wrap to 0 and tick (one tick every period cycles).
REQ-016 SHALL produce no ticks for period==0; the counter SHALL stay 0.
REQ-017 SHALL hold counter i at 0 and clear pending[i] while enable or chan_enable[i] is 0.
REQ-018 SHALL set pending[i] on a tick and clear it on grant; a tick in the grant cycle SHALL leave pending[i]=1.
REQ-019 SHALL set overrun[i] on a tick while pending[i]=1 without a grant that cycle; pending stays a single request with no queueing.
REQ-020 SHALL grant round-robin among pending channels, searching from last_grant+1 mod NCH; last_grant resets to NCH-1, so ch0 wins first.
REQ-021 SHALL implement FSM states IDLE, WAIT, GAP.
REQ-022 SHALL, in IDLE with enable=1 and any pending: grant the channel, latch its active_ch/amplitude/electrodes, set state to WAIT, and assert pulse_start for exactly one cycle on the next edge (registered, latency 1).
REQ-023 SHALL, in WAIT, move to GAP on pulse_done; after TIMEOUT cycles without pulse_done it SHALL set fault and move to GAP.
REQ-024 SHALL, in GAP, count GAP cycles and then return to IDLE; with GAP=0 it SHALL go from WAIT directly to IDLE.
REQ-025 SHALL assert busy in WAIT and GAP; amplitude_out SHALL be 0 whenever the state is not WAIT; electrode outputs SHALL hold their last values.
REQ-026 SHALL, on deassertion of enable during WAIT, not abort the pulse (charge balance): it SHALL complete WAIT and GAP, then stay IDLE.
REQ-027 SHALL ignore pulse_done outside WAIT.
REQ-028 SHALL clear fault on fault_clr; if a timeout and fault_clr occur in the same cycle, fault SHALL be set.
REQ-029 SHALL, while fault=1, issue no new grants; pending and overrun keep updating.
REQ-030 SHALL, for a cfg write to the channel currently in WAIT, not change the latched outputs of that pulse.

Reset
REQ-031 SHALL, on reset=1 (asynchronous): set state IDLE; counters, pending, overrun and fault to 0; pulse_start, busy, amplitude_out, electrode1_out, electrode2_out and active_ch to 0; last_grant to NCH-1; all config registers to 0.
REQ-032 SHALL, on reset asserted mid-pulse, drop amplitude_out to 0 immediately without waiting for a clock edge.

Structure
REQ-033 SHALL place NCH default, field widths (period 12, amplitude 6, electrode 4) and the FSM state encoding in shared package npg_pkg.
REQ-034 SHALL put the round-robin arbiter in sub-module npg_rr_arbiter (inputs: pending, last_grant, request_en; outputs: grant_valid, grant_idx).

Verification
REQ-035 SHALL verify: ch0 period=10, ch0 enabled, engine returns pulse_done 4 cycles after start -> pulse_start every 10 cycles, amplitude_out = cfg value during WAIT only.
REQ-036 SHALL verify: ch0..ch3 all period=20 and ticking in the same cycle -> grants in order 0,1,2,3, each start separated by WAIT+GAP, no overrun.
REQ-037 SHALL verify: ch1 period=3 with pulse_done delayed 8 cycles -> overrun[1]=1; a cfg write to ch1 -> overrun[1]=0.
REQ-038 SHALL verify: pulse_done never returned -> fault=1 after 255 WAIT cycles and no further pulse_start; fault_clr -> scheduling resumes.
REQ-039 SHALL verify: enable dropped 1 cycle after pulse_start -> busy stays high until pulse_done plus 2 GAP cycles, then no pulse_start.
REQ-040 SHALL verify: reset asserted mid-WAIT -> all outputs 0 asynchronously; first grant after release goes to ch0.
